// File: rtl/uart_key_rx_if.sv
// Signal bundle between the UART key receiver and its consumer.
// The receiver side (master) takes the RX pin and drives the byte/key results.
// The consumer side (slave) drives the pin and observes the results.
interface uart_key_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] key_value;
    logic       key_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output key_value,
        output key_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  key_value,
        input  key_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_key_rx.sv
// UART 8N1 receiver for host-PC control of the Battleship game.
// Deserialises frames from the USB-UART RX pin and turns ASCII hex characters
// ('0'-'9', 'A'-'F', 'a'-'f') into the keypad-style key_value/key_valid pair.
// Every bit is sampled mid-bit, timed from the start edge seen after the
// two-flop synchroniser.
module uart_key_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_key_rx_if.master  bus
);

    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Returns {match, value}; match is 0 for any byte that is not a hex digit.
    function automatic logic [4:0] key_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = {1'b1, b[3:0] + 4'd9};
        end
        return r;
    endfunction

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic [3:0]      key_value_q;
    logic            key_valid_q;
    logic            frame_err_q;
    logic            busy_q;
    logic            shift_en;
    logic [4:0]      key_dec;

    assign timer_d  = timer_q + TW'(1);
    assign shift_en = (state_q == DATA) && (timer_q == DIV_M1);
    assign key_dec  = key_decode(shift_q);

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.key_value = key_value_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

    // Two-flop synchroniser; resets to the idle (high) level so release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Data shift register, LSB first; contents only matter once STOP is reached, so no reset.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
        end
    end

    // Frame FSM with bit timer, bit index and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            key_value_q <= 4'd0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                START: begin
                    if (timer_q == HALF_M1) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            // Start bit gone by mid-bit: treat it as a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DATA: begin
                    if (timer_q == DIV_M1) begin
                        timer_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                STOP: begin
                    if (timer_q == DIV_M1) begin
                        timer_q <= '0;
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            if (key_dec[4]) begin
                                key_value_q <= key_dec[3:0];
                                key_valid_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Low stop bit: flag it and wait for the line to idle before re-arming.
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
